// File: rtl/ppa_pkg.sv
// Shared types and elaboration-time helpers for the pipelined Brent-Kung
// prefix adder.
//   bk_levels(width)             : number of Brent-Kung tree rows
//   ppa_latency(width, reg_every): register stages from input to output
//   pg_t                         : generate/propagate node pair
//   row_type_e                   : upsweep (black nodes) or downsweep (grey)
package ppa_pkg;

    typedef enum logic {
        UPSWEEP,
        DOWNSWEEP
    } row_type_e;

    typedef struct packed {
        logic g;
        logic p;
    } pg_t;

    function automatic int bk_levels(input int width);
        return 2 * $clog2(width) - 1;
    endfunction

    // Input register + one register per REG_EVERY rows (none after the last
    // row) + output register.
    function automatic int ppa_latency(input int width, input int reg_every);
        return 2 + (bk_levels(width) - 1) / reg_every;
    endfunction

endpackage

// File: rtl/buffer_node.sv
// Buffer node: pass-through for positions with no prefix operation in a row.
// Ports: i_pg (node in), o (node out).
module buffer_node
    import ppa_pkg::*;
(
    input  pg_t i_pg,
    output pg_t o
);

    assign o = i_pg;

endmodule

// File: rtl/ppa_bk_row.sv
// One combinational row of the Brent-Kung tree.
// Rows 1..log2(WIDTH) are the upsweep: position i gets a black node when
// (i+1) is a multiple of 2^ROW, pairing with i-2^(ROW-1).
// The remaining rows are the downsweep with d = 2*log2(WIDTH)-ROW: position i
// gets a grey node when (i+1) mod 2^d == 2^(d-1) and i >= 2^d, pairing with
// i-2^(d-1). All other positions are buffers.
// Ports: pg_i (node pairs entering the row), pg_o (node pairs leaving it).
module ppa_bk_row
    import ppa_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ROW   = 1
) (
    input  pg_t [WIDTH-1:0] pg_i,
    output pg_t [WIDTH-1:0] pg_o
);

    localparam int        LOG2W = $clog2(WIDTH);
    localparam row_type_e RTYPE = (ROW <= LOG2W) ? UPSWEEP : DOWNSWEEP;
    localparam int        SPAN  = (RTYPE == UPSWEEP) ? (1 << ROW) : (1 << (2 * LOG2W - ROW));
    localparam int        DIST  = SPAN / 2;

    for (genvar i = 0; i < WIDTH; i++) begin : g_pos
        if ((RTYPE == UPSWEEP) && (((i + 1) % SPAN) == 0)) begin : g_black
            ppa_black u_node (
                .hi (pg_i[i]),
                .lo (pg_i[i-DIST]),
                .o  (pg_o[i])
            );
        end else if ((RTYPE == DOWNSWEEP) && (((i + 1) % SPAN) == DIST) && (i >= SPAN)) begin : g_grey
            ppa_grey u_node (
                .hi   (pg_i[i]),
                .lo_g (pg_i[i-DIST].g),
                .o    (pg_o[i])
            );
        end else begin : g_buf
            buffer_node u_node (
                .i_pg (pg_i[i]),
                .o    (pg_o[i])
            );
        end
    end

endmodule

// File: rtl/ppa_black.sv
// Black prefix node: combines a high span with the adjacent low span and
// produces both group generate and group propagate.
// Ports: hi (upper span), lo (lower span), o (combined span).
module ppa_black
    import ppa_pkg::*;
(
    input  pg_t hi,
    input  pg_t lo,
    output pg_t o
);

    assign o.g = hi.g | (hi.p & lo.g);
    assign o.p = hi.p & lo.p;

endmodule

// File: rtl/ppa_grey.sv
// Grey prefix node: the low span already reaches bit 0, so only the group
// generate is needed. The propagate is passed through untouched.
// Ports: hi (upper span), lo_g (generate of the complete lower prefix), o.
module ppa_grey
    import ppa_pkg::*;
(
    input  pg_t  hi,
    input  logic lo_g,
    output pg_t  o
);

    assign o.g = hi.g | (hi.p & lo_g);
    assign o.p = hi.p;

endmodule

// File: rtl/ppa_pipe_adder.sv
// Pipelined Brent-Kung adder/subtractor with valid/ready flow control.
// Stage 0 registers a, b^{sub} and the effective carry-in; the tree rows
// follow with a register after every REG_EVERY rows (never after the last);
// the XOR post-processing result is registered in the output stage.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid / in_ready   operand beat handshake (a, b, cin, sub)
//   out_valid / out_ready result beat handshake (sum, cout, ovf)
//   sub=1 computes a-b; cin is ignored then. cout=1 means no borrow.
//   ovf = carry into MSB ^ carry out of MSB.
module ppa_pipe_adder
    import ppa_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int REG_EVERY = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int LEVELS = bk_levels(WIDTH);
    localparam int LAT    = ppa_latency(WIDTH, REG_EVERY);

    // ---------------- stage valids and load enables ----------------
    logic [LAT-1:0] v_q, v_d, stg_load;

    // A stage can load iff the consumer pops or some stage at or below it
    // (towards the output) is empty: the closed form of ~v[k] | adv[k].
    always_comb begin
        logic all_full;
        all_full = 1'b1;
        stg_load = '0;
        for (int k = LAT - 1; k >= 0; k--) begin
            all_full    = all_full & v_q[k];
            stg_load[k] = out_ready | ~all_full;
        end
    end

    always_comb begin
        v_d    = v_q;
        v_d[0] = stg_load[0] ? in_valid : v_q[0];
        for (int k = 1; k < LAT; k++) begin
            if (stg_load[k]) begin
                v_d[k] = v_q[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_q <= '0;
        end else begin
            v_q <= v_d;
        end
    end

    assign in_ready  = stg_load[0];
    assign out_valid = v_q[LAT-1];

    // ---------------- stage 0: operand capture ----------------
    logic [WIDTH-1:0] a_q, a_d, bx_q, bx_d;
    logic             cx_q, cx_d;
    logic             take0;

    assign take0 = stg_load[0] & in_valid;

    always_comb begin
        a_d  = a_q;
        bx_d = bx_q;
        cx_d = cx_q;
        if (take0) begin
            a_d  = a;
            bx_d = b ^ {WIDTH{sub}};
            cx_d = sub | cin;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q  <= '0;
            bx_q <= '0;
            cx_q <= 1'b0;
        end else begin
            a_q  <= a_d;
            bx_q <= bx_d;
            cx_q <= cx_d;
        end
    end

    // ---------------- prefix tree ----------------
    // Link r is what row r+1 sees: node pairs, raw propagate for the sum
    // XOR, and the carry-in needed for bit 0 of the sum.
    pg_t  [WIDTH-1:0] pg_lnk [LEVELS+1];
    logic [WIDTH-1:0] p_lnk  [LEVELS+1];
    logic [LEVELS:0]  c0_lnk;

    assign p_lnk[0]  = a_q ^ bx_q;
    assign c0_lnk[0] = cx_q;

    // Carry-in is folded into bit 0's generate so every prefix G[i:0] is
    // directly the carry out of bit i.
    for (genvar i = 0; i < WIDTH; i++) begin : g_pre
        assign pg_lnk[0][i].p = a_q[i] ^ bx_q[i];
        if (i == 0) begin : g_lsb
            assign pg_lnk[0][i].g = (a_q[i] & bx_q[i]) | ((a_q[i] ^ bx_q[i]) & cx_q);
        end else begin : g_bit
            assign pg_lnk[0][i].g = a_q[i] & bx_q[i];
        end
    end

    for (genvar r = 1; r <= LEVELS; r++) begin : g_row
        pg_t [WIDTH-1:0] pg_out;

        ppa_bk_row #(
            .WIDTH (WIDTH),
            .ROW   (r)
        ) u_row (
            .pg_i (pg_lnk[r-1]),
            .pg_o (pg_out)
        );

        if (((r % REG_EVERY) == 0) && (r < LEVELS)) begin : g_reg
            localparam int STG = r / REG_EVERY;
            pg_t  [WIDTH-1:0] rpg_q, rpg_d;
            logic [WIDTH-1:0] rp_q, rp_d;
            logic             rc_q, rc_d;
            logic             take;

            assign take = stg_load[STG] & v_q[STG-1];

            always_comb begin
                rpg_d = rpg_q;
                rp_d  = rp_q;
                rc_d  = rc_q;
                if (take) begin
                    rpg_d = pg_out;
                    rp_d  = p_lnk[r-1];
                    rc_d  = c0_lnk[r-1];
                end
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    rpg_q <= '0;
                    rp_q  <= '0;
                    rc_q  <= 1'b0;
                end else begin
                    rpg_q <= rpg_d;
                    rp_q  <= rp_d;
                    rc_q  <= rc_d;
                end
            end

            assign pg_lnk[r]  = rpg_q;
            assign p_lnk[r]   = rp_q;
            assign c0_lnk[r]  = rc_q;
        end else begin : g_comb
            assign pg_lnk[r]  = pg_out;
            assign p_lnk[r]   = p_lnk[r-1];
            assign c0_lnk[r]  = c0_lnk[r-1];
        end
    end

    // ---------------- post-processing and output stage ----------------
    logic [WIDTH-1:0] carry_vec;
    logic             cout_pre, ovf_pre;

    always_comb begin
        carry_vec[0] = c0_lnk[LEVELS];
        for (int i = 1; i < WIDTH; i++) begin
            carry_vec[i] = pg_lnk[LEVELS][i-1].g;
        end
        cout_pre = pg_lnk[LEVELS][WIDTH-1].g;
        ovf_pre  = carry_vec[WIDTH-1] ^ cout_pre;
    end

    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d, ovf_q, ovf_d;
    logic             take_o;

    assign take_o = stg_load[LAT-1] & v_q[LAT-2];

    always_comb begin
        sum_d  = sum_q;
        cout_d = cout_q;
        ovf_d  = ovf_q;
        if (take_o) begin
            sum_d  = p_lnk[LEVELS] ^ carry_vec;
            cout_d = cout_pre;
            ovf_d  = ovf_pre;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
            ovf_q  <= ovf_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_ppa_pipe_adder.sv
module tb_ppa_pipe_adder;

    localparam int LAT32 = 6;   // W=32, RE=2: 9 rows, regs after rows 2,4,6,8
    localparam int LAT16 = 5;   // W=16, RE=2: 7 rows, regs after rows 2,4,6
    localparam int LAT64 = 2;   // W=64, RE=11: no mid registers

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // 32-bit instance
    logic        iv32, ir32, cin32, sub32, ov32, or32, co32, ovf32;
    logic [31:0] a32, b32, sum32;
    // 16-bit instance
    logic        iv16, ir16, cin16, sub16, ov16, or16, co16, ovf16;
    logic [15:0] a16, b16, sum16;
    // 64-bit instance
    logic        iv64, ir64, cin64, sub64, ov64, or64, co64, ovf64;
    logic [63:0] a64, b64, sum64;

    ppa_pipe_adder #(.WIDTH(32), .REG_EVERY(2)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32),
        .cin(cin32), .sub(sub32), .out_valid(ov32), .out_ready(or32), .sum(sum32),
        .cout(co32), .ovf(ovf32));

    ppa_pipe_adder #(.WIDTH(16), .REG_EVERY(2)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
        .cin(cin16), .sub(sub16), .out_valid(ov16), .out_ready(or16), .sum(sum16),
        .cout(co16), .ovf(ovf16));

    ppa_pipe_adder #(.WIDTH(64), .REG_EVERY(11)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv64), .in_ready(ir64), .a(a64), .b(b64),
        .cin(cin64), .sub(sub64), .out_valid(ov64), .out_ready(or64), .sum(sum64),
        .cout(co64), .ovf(ovf64));

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] want);
        n_checks++;
        if (obs !== want) begin
            n_fails++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, want);
        end
    endtask

    // Arithmetic reference: {ovf, cout, sum}
    function automatic logic [33:0] model32(input logic [31:0] av, input logic [31:0] bv,
                                            input logic ci, input logic sb);
        logic [31:0] bb;
        logic        c0;
        logic [32:0] full;
        logic [31:0] low;
        bb   = sb ? ~bv : bv;
        c0   = sb ? 1'b1 : ci;
        full = {1'b0, av} + {1'b0, bb} + 33'(c0);
        low  = {1'b0, av[30:0]} + {1'b0, bb[30:0]} + 32'(c0);
        return {low[31] ^ full[32], full[32], full[31:0]};
    endfunction

    // Instance selection for the directed single-beat task
    int          sel = 32;
    logic        sel_ir, sel_ov, sel_co, sel_ovf;
    logic [63:0] sel_sum;
    always_comb begin
        sel_ir  = ir32;
        sel_ov  = ov32;
        sel_co  = co32;
        sel_ovf = ovf32;
        sel_sum = {32'h0, sum32};
        case (sel)
            16: begin
                sel_ir = ir16; sel_ov = ov16; sel_co = co16; sel_ovf = ovf16;
                sel_sum = {48'h0, sum16};
            end
            64: begin
                sel_ir = ir64; sel_ov = ov64; sel_co = co64; sel_ovf = ovf64;
                sel_sum = sum64;
            end
            default: ;
        endcase
    end

    // Drive one beat into an empty pipeline, measure latency, check result.
    // Entered and left at #1 after a rising edge.
    task automatic run_beat(input string tag, input int which,
                            input logic [63:0] av, input logic [63:0] bv,
                            input logic ci, input logic sb, input int exp_lat,
                            input logic [63:0] exp_sum, input logic exp_co, input logic exp_ovf);
        int lat;
        sel = which;
        case (which)
            16: begin iv16 = 1; a16 = av[15:0]; b16 = bv[15:0]; cin16 = ci; sub16 = sb; or16 = 1; end
            64: begin iv64 = 1; a64 = av;       b64 = bv;       cin64 = ci; sub64 = sb; or64 = 1; end
            default: begin iv32 = 1; a32 = av[31:0]; b32 = bv[31:0]; cin32 = ci; sub32 = sb; or32 = 1; end
        endcase
        @(negedge clk);
        check_eq({tag, "_in_ready"}, 64'(sel_ir), 64'd1);
        @(posedge clk); #1;
        iv16 = 0; iv32 = 0; iv64 = 0;
        for (lat = 1; lat <= 20; lat++) begin
            @(negedge clk);
            if (sel_ov) break;
            @(posedge clk); #1;
        end
        check_eq({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check_eq({tag, "_sum"}, sel_sum, exp_sum);
        check_eq({tag, "_cout"}, 64'(sel_co), 64'(exp_co));
        check_eq({tag, "_ovf"}, 64'(sel_ovf), 64'(exp_ovf));
        @(posedge clk); #1;
    endtask

    // Scoreboard / flow-control monitor for the 32-bit instance
    logic [33:0] sb_q[$];
    logic [33:0] want_r;
    bit          mon_en = 0;
    int          occ = 0, pops = 0, run_len = 0, max_run = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            check_eq("in_ready_model", 64'(ir32), 64'(!((occ == LAT32) && !or32)));
            if (ov32 && or32) begin
                check_eq("pop_has_entry", 64'(sb_q.size() != 0), 64'd1);
                if (sb_q.size() != 0) begin
                    want_r = sb_q.pop_front();
                    check_eq("stream_result", {30'h0, ovf32, co32, sum32}, {30'h0, want_r});
                end
                pops++;
                run_len++;
                if (run_len > max_run) max_run = run_len;
            end else begin
                run_len = 0;
            end
            if (iv32 && ir32) sb_q.push_back(model32(a32, b32, cin32, sub32));
            occ = occ + int'(iv32 && ir32) - int'(ov32 && or32);
        end
    end

    initial begin
        #700000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, guard, seen;
        rst_n = 0;
        iv32 = 0; a32 = 0; b32 = 0; cin32 = 0; sub32 = 0; or32 = 1;
        iv16 = 0; a16 = 0; b16 = 0; cin16 = 0; sub16 = 0; or16 = 1;
        iv64 = 0; a64 = 0; b64 = 0; cin64 = 0; sub64 = 0; or64 = 1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;

        // Reset state
        @(negedge clk);
        check_eq("rst_in_ready", 64'(ir32), 64'd1);
        check_eq("rst_out_valid", 64'(ov32), 64'd0);
        check_eq("rst_sum", 64'(sum32), 64'd0);
        check_eq("rst_cout_ovf", 64'({co32, ovf32}), 64'd0);
        check_eq("rst_out_valid16", 64'(ov16), 64'd0);
        check_eq("rst_out_valid64", 64'(ov64), 64'd0);
        @(posedge clk); #1;

        // Directed single beats
        run_beat("w32_sub_min", 32, 64'h8000_0000, 64'h1, 1'b1, 1'b1, LAT32, 64'h7FFF_FFFF, 1'b1, 1'b1);
        run_beat("w32_wrap",    32, 64'hFFFF_FFFF, 64'h1, 1'b0, 1'b0, LAT32, 64'h0, 1'b1, 1'b0);
        run_beat("w32_cin_ovf", 32, 64'h7FFF_FFFF, 64'h0, 1'b1, 1'b0, LAT32, 64'h8000_0000, 1'b0, 1'b1);
        run_beat("w32_borrow",  32, 64'h5, 64'h7, 1'b0, 1'b1, LAT32, 64'hFFFF_FFFE, 1'b0, 1'b0);
        run_beat("w32_sub_0",   32, 64'h0, 64'h0, 1'b0, 1'b1, LAT32, 64'h0, 1'b1, 1'b0);
        run_beat("w16_wrap",    16, 64'hFFFF, 64'h1, 1'b0, 1'b0, LAT16, 64'h0, 1'b1, 1'b0);
        run_beat("w16_cin",     16, 64'h1234, 64'h4321, 1'b1, 1'b0, LAT16, 64'h5556, 1'b0, 1'b0);
        run_beat("w64_ovf",     64, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, LAT64,
                 64'h8000_0000_0000_0000, 1'b0, 1'b1);
        run_beat("w64_sub_neg", 64, 64'h0, 64'h1, 1'b0, 1'b1, LAT64, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
        sel = 32;

        // Back-to-back stream of 100 beats, consumer always ready
        occ = 0; pops = 0; run_len = 0; max_run = 0; mon_en = 1; or32 = 1;
        for (int i = 0; i < 100; i++) begin
            iv32 = 1; a32 = $urandom; b32 = $urandom;
            cin32 = 1'($urandom_range(0, 1)); sub32 = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        iv32 = 0;
        repeat (LAT32 + 2) @(posedge clk);
        #1;
        check_eq("stream_pops", 64'(pops), 64'd100);
        check_eq("stream_run", 64'(max_run), 64'd100);

        // Fill under backpressure, then push and pop together while full
        or32 = 0;
        for (int i = 0; i < 8; i++) begin
            iv32 = 1; a32 = $urandom; b32 = $urandom; cin32 = 1'($urandom_range(0, 1)); sub32 = 0;
            @(posedge clk); #1;
        end
        check_eq("full_occupancy", 64'(occ), 64'(LAT32));
        or32 = 1;
        for (int i = 0; i < 4; i++) begin
            iv32 = 1; a32 = $urandom; b32 = $urandom; cin32 = 0; sub32 = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        check_eq("full_push_pop_occ", 64'(occ), 64'(LAT32));
        iv32 = 0;
        repeat (LAT32 + 2) @(posedge clk);
        #1;

        // Random valid and ready
        acc = 0; guard = 0;
        while (acc < 200 && guard < 5000) begin
            iv32 = 1'($urandom_range(0, 1)); a32 = $urandom; b32 = $urandom;
            cin32 = 1'($urandom_range(0, 1)); sub32 = 1'($urandom_range(0, 1));
            or32 = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (iv32 && ir32) acc++;
            @(posedge clk); #1;
            guard++;
        end
        check_eq("rand_accepted", 64'(acc), 64'd200);
        iv32 = 0; or32 = 1; guard = 0;
        while (sb_q.size() != 0 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        check_eq("rand_drained", 64'(sb_q.size()), 64'd0);
        mon_en = 0;

        // Reset with three beats in flight
        or32 = 0;
        for (int i = 0; i < 3; i++) begin
            iv32 = 1; a32 = 32'h1111_1111; b32 = 32'h2222_2222 * (i + 1); cin32 = 0; sub32 = 0;
            @(posedge clk); #1;
        end
        iv32 = 0;
        repeat (8) @(posedge clk);
        #1;
        @(negedge clk);
        check_eq("pre_rst_valid", 64'(ov32), 64'd1);
        check_eq("pre_rst_sum", 64'(sum32), 64'h3333_3333);
        @(posedge clk); #1 rst_n = 0;
        @(posedge clk); #1 rst_n = 1;
        @(negedge clk);
        check_eq("mid_rst_out_valid", 64'(ov32), 64'd0);
        check_eq("mid_rst_sum", 64'(sum32), 64'd0);
        check_eq("mid_rst_cout_ovf", 64'({co32, ovf32}), 64'd0);
        check_eq("mid_rst_in_ready", 64'(ir32), 64'd1);
        or32 = 1; seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (ov32) seen++;
        end
        check_eq("no_stale_beat", 64'(seen), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
